// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one pipelined multiplier between NUM_REQ requesters.
// Exactly one operation is in flight: accept -> issue write -> wait for the
// multiplier -> read -> capture product -> hold response until taken.
//
// Build option: define MUL_ARB_ROUND_ROBIN_EN for round-robin grant; without
// it the lowest-indexed requesting port wins (fixed priority).
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req_valid/req_a/b    per-requester request and flattened operands
//   req_ready            one-hot accept strobe (one cycle, IDLE only)
//   resp_valid/ready     one-hot result handshake for the owning requester
//   resp_data            registered product, stable while resp_valid is high
//   busy                 high whenever the FSM is not idle
//   mul_wr_*             operand write to the multiplier
//   mul_rd_*             product read from the multiplier
module mul_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [2*DATA_WIDTH-1:0]       resp_data,
    output logic                          busy,
    output logic                          mul_wr_en,
    output logic                          mul_rd_en,
    output logic [DATA_WIDTH-1:0]         mul_wr_data_1,
    output logic [DATA_WIDTH-1:0]         mul_wr_data_2,
    input  logic                          mul_wr_ready,
    input  logic                          mul_rd_ready,
    input  logic                          mul_rd_val,
    input  logic [2*DATA_WIDTH-1:0]       mul_rd_data
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StRead,
        StCapture,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q;
    logic [DATA_WIDTH-1:0]   op_a_q, op_b_q;
    logic [2*DATA_WIDTH-1:0] resp_data_q;

    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b;
    logic                    accept;

    // Grant selection
`ifdef MUL_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;

    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
        return IDX_W'(v % NUM_REQ);
    endfunction

    // Search starts one past the last winner and wraps around.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!grant_valid && req_valid[wrap_idx(32'(rr_ptr_q) + k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(32'(rr_ptr_q) + k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            rr_ptr_q <= grant_idx;
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && req_valid[IDX_W'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // Operand mux for the winning requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == grant_idx) begin
                sel_a = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                sel_b = req_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Reset is synchronous, so mask accepts while it is asserted.
    assign accept = (state_q == StIdle) && grant_valid && mul_wr_ready && !reset;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                owner_q <= grant_idx;
                op_a_q  <= sel_a;
                op_b_q  <= sel_b;
            end
            if (state_q == StCapture && mul_rd_val) begin
                resp_data_q <= mul_rd_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = StIssue;
            StIssue:   state_d = StWait;
            StWait:    if (mul_rd_ready) state_d = StRead;
            StRead:    state_d = StCapture;
            StCapture: if (mul_rd_val) state_d = StResp;
            StResp:    if (resp_ready[owner_q]) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs; strobes are held low during the reset cycle as well.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        mul_wr_en  = 1'b0;
        mul_rd_en  = 1'b0;
        busy       = 1'b0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (!reset) begin
            busy      = (state_q != StIdle);
            mul_wr_en = (state_q == StIssue);
            mul_rd_en = (state_q == StRead);
            if (state_q == StResp) begin
                resp_valid[owner_q] = 1'b1;
            end
        end
    end

    assign resp_data     = resp_data_q;
    assign mul_wr_data_1 = op_a_q;
    assign mul_wr_data_2 = op_b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter (DATA_WIDTH=32, NUM_REQ=2),
// with a behavioural multiplier that raises mul_rd_ready mul_lat+1 cycles
// after a write and returns the product the cycle after mul_rd_en.
// Grant expectations follow MUL_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mul_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_data;
    logic        busy;
    logic        mul_wr_en, mul_rd_en;
    logic [31:0] mul_wr_data_1, mul_wr_data_2;
    logic        mul_wr_ready, mul_rd_ready, mul_rd_val;
    logic [63:0] mul_rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int overlap_n = 0;
    int wr_total = 0;
    int rd_total = 0;
    int acc_total = 0;
    int unsigned mul_lat = 2;

    mul_arbiter #(
        .DATA_WIDTH(32),
        .NUM_REQ   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .busy         (busy),
        .mul_wr_en    (mul_wr_en),
        .mul_rd_en    (mul_rd_en),
        .mul_wr_data_1(mul_wr_data_1),
        .mul_wr_data_2(mul_wr_data_2),
        .mul_wr_ready (mul_wr_ready),
        .mul_rd_ready (mul_rd_ready),
        .mul_rd_val   (mul_rd_val),
        .mul_rd_data  (mul_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier, reset by the same net as the arbiter.
    logic [63:0] m_prod;
    logic        m_busy;
    int unsigned m_cnt;
    always @(posedge clk) begin
        if (reset) begin
            mul_rd_ready <= 1'b0;
            mul_rd_val   <= 1'b0;
            mul_rd_data  <= '0;
            m_prod       <= '0;
            m_busy       <= 1'b0;
            m_cnt        <= 0;
        end else begin
            mul_rd_val <= 1'b0;
            if (mul_wr_en) begin
                m_prod <= 64'(mul_wr_data_1) * 64'(mul_wr_data_2);
                m_cnt  <= mul_lat;
                m_busy <= 1'b1;
            end else if (m_busy && !mul_rd_ready) begin
                if (m_cnt == 0) mul_rd_ready <= 1'b1;
                else            m_cnt <= m_cnt - 1;
            end
            if (mul_rd_en) begin
                mul_rd_ready <= 1'b0;
                m_busy       <= 1'b0;
                mul_rd_val   <= 1'b1;
                mul_rd_data  <= m_prod;
            end
        end
    end

    // Protocol monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (mul_wr_en && mul_rd_en) overlap_n++;
            if (mul_wr_en) wr_total++;
            if (mul_rd_en) rd_total++;
            if (req_ready != 2'b00) acc_total++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Tracks one operation from accept to the first response cycle. Returns at
    // the negedge of that first RESP cycle; acc_c is the cycle of accept.
    task automatic run_op(input string tag, input logic [1:0] exp_grant,
                          input logic [63:0] exp_data, output int acc_c);
        int wr_n, rd_n, rr_n, t_wr, t_rdy, t_resp;
        logic [1:0] g;
        g = 2'b00; wr_n = 0; rd_n = 0; rr_n = 0;
        acc_c = -1; t_wr = -1; t_rdy = -1; t_resp = -1;
        for (int c = 0; c < 100 && t_resp < 0; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                rr_n++;
                if (acc_c < 0) begin
                    acc_c = c;
                    g = req_ready;
                end
            end
            if (mul_wr_en) begin
                wr_n++;
                if (t_wr < 0) t_wr = c;
            end
            if (mul_rd_en) rd_n++;
            if (t_wr >= 0 && t_rdy < 0 && mul_rd_ready) t_rdy = c;
            if (resp_valid != 2'b00) begin
                t_resp = c;
                check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'(exp_grant));
                check_eq({tag, "_resp_data"}, resp_data, exp_data);
            end
        end
        check_eq({tag, "_done"}, 64'(t_resp >= 0), 64'd1);
        check_eq({tag, "_grant"}, 64'(g), 64'(exp_grant));
        check_eq({tag, "_ready_pulses"}, 64'(rr_n), 64'd1);
        check_eq({tag, "_wr_pulses"}, 64'(wr_n), 64'd1);
        check_eq({tag, "_rd_pulses"}, 64'(rd_n), 64'd1);
        check_eq({tag, "_wr_latency"}, 64'(t_wr - acc_c), 64'd1);
        check_eq({tag, "_resp_latency"}, 64'(t_resp - t_rdy), 64'd3);
    endtask

    initial begin
        int acc_c;
        logic [1:0]  exp_g;
        logic [63:0] exp_d;
        bit seen_wr;

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        resp_ready = 2'b11; mul_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_strobes", 64'({mul_wr_en, mul_rd_en}), 64'd0);
        check_eq("rst_resp_data", resp_data, 64'd0);
        check_eq("rst_wr_data", 64'({mul_wr_data_1, mul_wr_data_2}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Contention: both requesters held valid for four operations.
        req_a = {32'd4, 32'd2};
        req_b = {32'd5, 32'd3};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
`ifdef MUL_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            exp_d = (exp_g == 2'b01) ? 64'd6 : 64'd20;
            run_op($sformatf("contend%0d", i), exp_g, exp_d, acc_c);
        end
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("contend_idle_busy", 64'(busy), 64'd0);

        // Single request 7*6; operands must stay on the write bus afterwards.
        @(posedge clk); #1;
        req_a = {32'd0, 32'd7};
        req_b = {32'd0, 32'd6};
        req_valid = 2'b01;
        run_op("single", 2'b01, 64'd42, acc_c);
        req_valid = 2'b00;
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        check_eq("single_idle_ready", 64'(req_ready), 64'd0);
        check_eq("hold_wr_data_1", 64'(mul_wr_data_1), 64'd7);
        check_eq("hold_wr_data_2", 64'(mul_wr_data_2), 64'd6);

        // Multiplier not ready for writes: no accept until released.
        @(posedge clk); #1;
        mul_wr_ready = 1'b0;
        req_a = {32'd0, 32'd9};
        req_b = {32'd0, 32'd9};
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_no_ready", 64'({busy, req_ready}), 64'd0);
        end
        @(posedge clk); #1;
        mul_wr_ready = 1'b1;
        run_op("stall", 2'b01, 64'd81, acc_c);
        check_eq("stall_accept_cycle", 64'(acc_c), 64'd0);
        req_valid = 2'b00;

        // Backpressure on requester 1; requester 0 waits and its
        // resp_ready bit must not complete requester 1's response.
        @(posedge clk); #1;
        req_a = {32'hFFFF_FFFF, 32'd10};
        req_b = {32'd2, 32'd11};
        req_valid = 2'b10;
        resp_ready = 2'b01;
        run_op("bp", 2'b10, 64'h1_FFFF_FFFE, acc_c);
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_resp_valid", 64'(resp_valid), 64'h2);
            check_eq("bp_resp_data", resp_data, 64'h1_FFFF_FFFE);
            check_eq("bp_no_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 2'b11;
        run_op("after_bp", 2'b01, 64'd110, acc_c);
        check_eq("after_bp_accept_cycle", 64'(acc_c), 64'd0);
        req_valid = 2'b00;

        // Reset while waiting on the multiplier abandons the operation.
        @(posedge clk); #1;
        mul_lat = 10;
        req_a = {32'd0, 32'd100};
        req_b = {32'd0, 32'd100};
        req_valid = 2'b01;
        seen_wr = 1'b0;
        for (int c = 0; c < 20 && !seen_wr; c++) begin
            @(negedge clk);
            if (mul_wr_en) seen_wr = 1'b1;
        end
        check_eq("midrst_wr_seen", 64'(seen_wr), 64'd1);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        check_eq("midrst_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mul_lat = 2;
        @(negedge clk);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("midrst_resp_data", resp_data, 64'd0);
        check_eq("midrst_wr_data", 64'({mul_wr_data_1, mul_wr_data_2}), 64'd0);
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (resp_valid != 2'b00 || busy) stray++;
            end
            check_eq("midrst_no_resp", 64'(stray), 64'd0);
        end
        @(posedge clk); #1;
        req_a = {32'd0, 32'd3};
        req_b = {32'd0, 32'd5};
        req_valid = 2'b01;
        run_op("fresh", 2'b01, 64'd15, acc_c);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);

        check_eq("wr_rd_overlap", 64'(overlap_n), 64'd0);
        check_eq("total_accepts", 64'(acc_total), 64'd10);
        check_eq("total_wr", 64'(wr_total), 64'd10);
        check_eq("total_rd", 64'(rd_total), 64'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand width, SHALL match the attached multiplier.
REQ-002 Parameter NUM_REQ, default 2: number of requesters (2..8); IDX_W = $clog2(NUM_REQ).
REQ-003 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  NUM_REQ  per-requester operation request.
REQ-005 req_a, req_b  in  NUM_REQ*DATA_WIDTH each  flattened operands; requester i uses bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-006 req_ready  out  NUM_REQ  one-hot accept strobe.
REQ-007 resp_valid  out  NUM_REQ  one-hot result valid; resp_ready  in  NUM_REQ  result taken.
REQ-008 resp_data  out  2*DATA_WIDTH  product for the requester flagged in resp_valid.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 Multiplier side: mul_wr_en, mul_rd_en out 1; mul_wr_data_1, mul_wr_data_2 out DATA_WIDTH; mul_wr_ready, mul_rd_ready, mul_rd_val in 1; mul_rd_data in 2*DATA_WIDTH.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT, READ, CAPTURE, RESP; exactly one operation in flight.
REQ-012 IDLE: when any req_valid=1 and mul_wr_ready=1, req_ready[g]=1 for that cycle only (g = grant winner), operands of g latched, owner<=g, next state ISSUE; else stay.
REQ-013 req_ready SHALL be 0 outside IDLE and 0 in IDLE when mul_wr_ready=0.
REQ-014 ISSUE: mul_wr_en=1 for exactly one cycle, mul_wr_data_1/2 driven from latched operands; next WAIT.
REQ-015 WAIT: hold until mul_rd_ready=1, then next READ; mul_wr_en=mul_rd_en=0.
REQ-016 READ: mul_rd_en=1 for exactly one cycle; next CAPTURE.
REQ-017 CAPTURE: when mul_rd_val=1, resp_data register <= mul_rd_data, next RESP; otherwise stay.
REQ-018 RESP: resp_valid[owner]=1 and resp_data stable until resp_ready[owner]=1; that cycle next IDLE; resp_ready of other bits ignored.
REQ-019 mul_wr_data_1/2 SHALL hold latched operands from ISSUE until next accept.
REQ-020 Minimum latency: accept at cycle T -> mul_wr_en at T+1 -> resp_valid at (first mul_rd_ready cycle)+3.
REQ-021 A requester dropping req_valid while not granted SHALL lose nothing; a granted request is never cancelled.
REQ-022 Next accept earliest the cycle after the RESP handshake (IDLE re-entered); back-to-back same-cycle response and accept not permitted.

Reset
REQ-023 reset SHALL force IDLE, all outputs 0 (req_ready, resp_valid, mul_wr_en, mul_rd_en, busy, resp_data, mul_wr_data_1/2), owner=0, RR pointer=NUM_REQ-1.
REQ-024 Reset mid-operation SHALL abandon the in-flight operation without response; multiplier is reset by the same reset net.

Configuration
REQ-025 Macro MUL_ARB_ROUND_ROBIN_EN defined: grant = first requester with req_valid=1 searching from pointer+1 upward with wrap; pointer<=g on each accept.
REQ-026 Macro undefined: fixed priority, lowest index with req_valid=1 wins; pointer logic absent.

Verification
REQ-027 Single request: req_valid[0]=1, a=7, b=6 -> req_ready[0] one pulse, one mul_wr_en, one mul_rd_en, resp_valid[0]=1 with resp_data=42.
REQ-028 Contention, RR build: req_valid=2'b11 held, four operations -> grants 0,1,0,1; without macro -> 0,0,0,0.
REQ-029 Backpressure: resp_ready[1]=0 for 10 cycles in RESP -> resp_valid[1] and resp_data (0xFFFFFFFF*2=0x1_FFFFFFFE) stable, no new req_ready pulse.
REQ-030 mul_wr_ready forced 0 in IDLE with req_valid=1 -> no req_ready; release -> accept next cycle.
REQ-031 reset asserted in WAIT -> next cycle IDLE, busy=0, resp_valid=0; fresh request a=3, b=5 -> resp_data=15.
REQ-032 Protocol checker throughout: mul_wr_en and mul_rd_en never high together, each exactly once per accepted request.
